// File: rtl/icache_pkg.sv
// Shared types and widths for the instruction cache slice.
package icache_pkg;

    localparam int unsigned INSTR_WIDTH     = 32;
    localparam int unsigned BLOCK_WIDTH     = 128;
    localparam int unsigned MEM_ADDR_WIDTH  = 28;
    localparam int unsigned WORDS_PER_BLOCK = BLOCK_WIDTH / INSTR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2
    } icache_state_e;

    // Word 0 of a block occupies bits [31:0].
    function automatic logic [INSTR_WIDTH-1:0] block_word(
        input logic [BLOCK_WIDTH-1:0] blk,
        input logic [1:0]             off
    );
        return blk[INSTR_WIDTH*int'(off) +: INSTR_WIDTH];
    endfunction

endpackage

// File: rtl/icache_if.sv
// Block-read bus between the cache (master) and instruction memory (slave).
interface icache_if;
    import icache_pkg::*;

    logic                      MEM_READ;
    logic [MEM_ADDR_WIDTH-1:0] MEM_ADDRESS;
    logic [BLOCK_WIDTH-1:0]    MEM_READDATA;
    logic                      MEM_BUSYWAIT;

    modport master (
        output MEM_READ,
        output MEM_ADDRESS,
        input  MEM_READDATA,
        input  MEM_BUSYWAIT
    );

    modport slave (
        input  MEM_READ,
        input  MEM_ADDRESS,
        output MEM_READDATA,
        output MEM_BUSYWAIT
    );

endinterface

// File: rtl/icache_fsm.sv
// Miss-handling controller: state register, miss-address latch, MEM_READ and stall decode.
module icache_fsm
    import icache_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      read_i,
    input  logic                      hit_i,
    input  logic [MEM_ADDR_WIDTH-1:0] block_addr_i,
    icache_if.master                  mem,
    output logic                      busywait_o,
    output logic                      fill_en_o,
    output logic                      idle_o
);

    icache_state_e             state_q;
    logic                      mem_read_q;
    logic [MEM_ADDR_WIDTH-1:0] miss_addr_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            mem_read_q  <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (read_i && !hit_i) begin
                        state_q     <= ST_MEM_READ;
                        mem_read_q  <= 1'b1;
                        miss_addr_q <= block_addr_i;
                    end
                end
                ST_MEM_READ: begin
                    if (!mem.MEM_BUSYWAIT) begin
                        state_q    <= ST_UPDATE;
                        mem_read_q <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem.MEM_READ    = mem_read_q;
    assign mem.MEM_ADDRESS = miss_addr_q;

    // hit_i is only ever true in IDLE, so a miss stall starts in the request cycle.
    assign busywait_o = (state_q != ST_IDLE) | (read_i & ~hit_i);
    assign fill_en_o  = (state_q == ST_UPDATE);
    assign idle_o     = (state_q == ST_IDLE);

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 2^INDEX_BITS lines of four 32-bit words.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      READ,
    input  logic [31:0]               ADDRESS,
    output logic [INSTR_WIDTH-1:0]    INSTRUCTION,
    output logic                      BUSYWAIT,
    output logic                      MEM_READ,
    output logic [MEM_ADDR_WIDTH-1:0] MEM_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0]    MEM_READDATA,
    input  logic                      MEM_BUSYWAIT
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = MEM_ADDR_WIDTH - INDEX_BITS;

    icache_if mem_bus ();

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  unused_addr_bits;

    logic [BLOCK_WIDTH-1:0] data_q [LINES];
    logic [TAG_BITS-1:0]    tag_q  [LINES];
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       valid_d;

    logic                  hit;
    logic                  idle;
    logic                  fill_en;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;

    assign offset           = ADDRESS[3:2];
    assign index            = ADDRESS[3+INDEX_BITS:4];
    assign tag              = ADDRESS[31:4+INDEX_BITS];
    assign unused_addr_bits = ^ADDRESS[1:0];

    assign mem_bus.MEM_READDATA = MEM_READDATA;
    assign mem_bus.MEM_BUSYWAIT = MEM_BUSYWAIT;
    assign MEM_READ             = mem_bus.MEM_READ;
    assign MEM_ADDRESS          = mem_bus.MEM_ADDRESS;

    // The fill target comes from the latched block address, never from the live ADDRESS.
    assign fill_index = mem_bus.MEM_ADDRESS[INDEX_BITS-1:0];
    assign fill_tag   = mem_bus.MEM_ADDRESS[MEM_ADDR_WIDTH-1:INDEX_BITS];

    assign hit         = idle & READ & valid_q[index] & (tag_q[index] == tag);
    assign INSTRUCTION = block_word(data_q[index], offset);

    icache_fsm u_fsm (
        .CLK          (CLK),
        .RESET        (RESET),
        .read_i       (READ),
        .hit_i        (hit),
        .block_addr_i (ADDRESS[31:4]),
        .mem          (mem_bus.master),
        .busywait_o   (BUSYWAIT),
        .fill_en_o    (fill_en),
        .idle_o       (idle)
    );

    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[fill_index] <= mem_bus.MEM_READDATA;
            tag_q[fill_index]  <= fill_tag;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fill_index] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a 16-cycle block memory model.
module tb_icache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        rd;
    logic [31:0] addr_r;
    logic [31:0] INSTRUCTION;
    logic        BUSYWAIT;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned mem_cnt = 0;

    icache_if mif ();

    icache #(.INDEX_BITS(3)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (rd),
        .ADDRESS      (addr_r),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (mif.MEM_READ),
        .MEM_ADDRESS  (mif.MEM_ADDRESS),
        .MEM_READDATA (mif.MEM_READDATA),
        .MEM_BUSYWAIT (mif.MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Word w of block b reads as (w+1)*0x10000000 + b.
    always @(posedge CLK) begin
        if (mif.MEM_READ) mem_cnt <= mem_cnt + 1;
        else              mem_cnt <= 0;
    end

    assign mif.MEM_BUSYWAIT = mif.MEM_READ && (mem_cnt < 15);

    always_comb begin
        mif.MEM_READDATA = {32'h4000_0000 + {4'h0, mif.MEM_ADDRESS},
                            32'h3000_0000 + {4'h0, mif.MEM_ADDRESS},
                            32'h2000_0000 + {4'h0, mif.MEM_ADDRESS},
                            32'h1000_0000 + {4'h0, mif.MEM_ADDRESS}};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic miss_fill(input logic [31:0] a, input logic [27:0] blk, input logic [31:0] word0);
        int unsigned n;
        bit          done;
        @(negedge CLK);
        rd     = 1'b1;
        addr_r = a;
        #1;
        chk("miss_detect", {31'b0, BUSYWAIT}, 32'd1);
        chk("miss_memrd_lo", {31'b0, mif.MEM_READ}, 32'd0);
        n    = 1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLK);
            #1;
            if (i == 0) begin
                chk("memrd_req", {31'b0, mif.MEM_READ}, 32'd1);
                chk("mem_addr", {4'h0, mif.MEM_ADDRESS}, {4'h0, blk});
            end
            if (BUSYWAIT) n++;
            else          done = 1'b1;
        end
        chk("stall_cycles", n, 32'd18);
        chk("fill_instr", INSTRUCTION, word0);
        chk("idle_memrd", {31'b0, mif.MEM_READ}, 32'd0);
        chk("held_addr", {4'h0, mif.MEM_ADDRESS}, {4'h0, blk});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        RESET  = 1'b1;
        rd     = 1'b0;
        addr_r = '0;
        #12;
        chk("rst_memrd", {31'b0, mif.MEM_READ}, 32'd0);
        chk("rst_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("rst_addr", {4'h0, mif.MEM_ADDRESS}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // cold miss, then spatial hits in the same block
        miss_fill(32'h0000_0000, 28'h000_0000, 32'h1000_0000);
        @(negedge CLK); addr_r = 32'h4; #1;
        chk("hit4_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("hit4_instr", INSTRUCTION, 32'h2000_0000);
        @(negedge CLK); addr_r = 32'h8; #1;
        chk("hit8_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("hit8_instr", INSTRUCTION, 32'h3000_0000);
        @(negedge CLK); addr_r = 32'hC; #1;
        chk("hitC_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("hitC_instr", INSTRUCTION, 32'h4000_0000);
        @(negedge CLK); addr_r = 32'h7; #1;
        chk("lowbits_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("lowbits_instr", INSTRUCTION, 32'h2000_0000);

        // conflict on index 0
        miss_fill(32'h0000_0080, 28'h000_0008, 32'h1000_0008);
        @(negedge CLK); addr_r = 32'h84; #1;
        chk("conf_hit_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("conf_hit_instr", INSTRUCTION, 32'h2000_0008);
        miss_fill(32'h0000_0000, 28'h000_0000, 32'h1000_0000);

        // reset five cycles into a fill
        @(negedge CLK); addr_r = 32'h100; #1;
        chk("mf_detect", {31'b0, BUSYWAIT}, 32'd1);
        repeat (5) @(negedge CLK);
        #1;
        chk("mf_memrd", {31'b0, mif.MEM_READ}, 32'd1);
        RESET = 1'b1;
        rd    = 1'b0;
        #1;
        chk("mf_abort_memrd", {31'b0, mif.MEM_READ}, 32'd0);
        chk("mf_abort_busy", {31'b0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("mf_rel_busy", {31'b0, BUSYWAIT}, 32'd0);
        chk("mf_rel_addr", {4'h0, mif.MEM_ADDRESS}, 32'd0);
        @(negedge CLK); #1;
        chk("mf_stay_idle", {31'b0, mif.MEM_READ}, 32'd0);
        miss_fill(32'h0000_0000, 28'h000_0000, 32'h1000_0000);
        miss_fill(32'h0000_0100, 28'h000_0010, 32'h1000_0010);

        // idle with wandering address
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            rd     = 1'b0;
            addr_r = 32'h44 * i;
            #1;
            chk("idle_busy", {31'b0, BUSYWAIT}, 32'd0);
            chk("idle_memrd", {31'b0, mif.MEM_READ}, 32'd0);
        end

        // address moves away while the fill for 0x0 is in flight
        @(negedge CLK); rd = 1'b1; addr_r = 32'h0; #1;
        chk("chg_detect", {31'b0, BUSYWAIT}, 32'd1);
        @(negedge CLK); addr_r = 32'h40; #1;
        chk("chg_memrd", {31'b0, mif.MEM_READ}, 32'd1);
        chk("chg_addr", {4'h0, mif.MEM_ADDRESS}, 32'd0);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK); #1;
            if (!mif.MEM_READ) done = 1'b1;
            else chk("chg_addr_hold", {4'h0, mif.MEM_ADDRESS}, 32'd0);
        end
        chk("chg_fill_done", {31'b0, done}, 32'd1);
        chk("chg_upd_busy", {31'b0, BUSYWAIT}, 32'd1);
        chk("chg_upd_addr", {4'h0, mif.MEM_ADDRESS}, 32'd0);
        @(negedge CLK); #1;
        chk("line4_invalid", {31'b0, BUSYWAIT}, 32'd1);
        addr_r = 32'h0; #1;
        chk("line0_hit", {31'b0, BUSYWAIT}, 32'd0);
        chk("line0_instr", INSTRUCTION, 32'h1000_0000);
        rd = 1'b0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
